// File: rtl/line_mem_arbiter.sv
// line_mem_arbiter: shares one 64-bit burst memory port between the icache and
// the dcache. Each 256-bit line transfer becomes a 4-beat burst. A local line
// buffer collects read beats or serialises a writeback line.
module line_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // icache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    // dcache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    // burst memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    // Clears the byte offset within a line so bursts are always line aligned.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        D_WR,
        D_RD,
        I_RD,
        DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [CNT_W-1:0]    cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic [LINE_W-1:0]   line_reg;
    logic [LINE_W-1:0]   line_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   addr_next;
    logic                owner_reg;     // 0 = icache, 1 = dcache
    logic                owner_next;
    logic [LINE_W-1:0]   i_rdata_reg;
    logic [LINE_W-1:0]   i_rdata_next;
    logic [LINE_W-1:0]   d_rdata_reg;
    logic [LINE_W-1:0]   d_rdata_next;

    // Control strobes produced by the FSM and consumed by the datapath.
    logic                grant;
    logic                grant_d;
    logic                grant_wr;
    logic                in_burst;
    logic                beat_ack;
    logic                rd_beat;
    logic                last_beat;

    // Per-beat view of the line buffer, used to select the outgoing write beat.
    logic [BEAT_W-1:0]   line_beat [BEATS];

    // Beat handshake qualifiers: mem_resp only counts while a burst is in flight.
    assign in_burst  = (state_reg == D_WR) || (state_reg == D_RD) || (state_reg == I_RD);
    assign beat_ack  = mem_resp && in_burst;
    assign rd_beat   = beat_ack && (state_reg != D_WR);
    assign last_beat = beat_ack && (cnt_reg == LAST_BEAT);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state, arbitration and handshake outputs.
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        grant_d    = 1'b0;
        grant_wr   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Fixed priority: dcache writeback, dcache read, icache read.
                // A simultaneous d_read/d_write is served as a writeback.
                if (d_write) begin
                    state_next = D_WR;
                    grant      = 1'b1;
                    grant_d    = 1'b1;
                    grant_wr   = 1'b1;
                end else if (d_read) begin
                    state_next = D_RD;
                    grant      = 1'b1;
                    grant_d    = 1'b1;
                end else if (i_read) begin
                    state_next = I_RD;
                    grant      = 1'b1;
                end
            end

            D_WR: begin
                mem_write = 1'b1;
                if (last_beat) begin
                    state_next = DONE;
                end
            end

            D_RD, I_RD: begin
                mem_read = 1'b1;
                if (last_beat) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                // Requests are deliberately not sampled here; the requester
                // needs this cycle to drop its request after seeing resp.
                d_resp     = owner_reg;
                i_resp     = ~owner_reg;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line buffer slices: a writeback grant loads the whole line, each read
    // beat overwrites only the slice selected by the beat counter.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign line_beat[gi] = line_reg[gi*BEAT_W +: BEAT_W];
        assign line_next[gi*BEAT_W +: BEAT_W] =
            grant_wr                                  ? d_wdata[gi*BEAT_W +: BEAT_W] :
            (rd_beat && (cnt_reg == CNT_W'(gi)))      ? mem_rdata :
                                                        line_reg[gi*BEAT_W +: BEAT_W];
    end

    // Counter, address, owner and returned-line next-state logic.
    always_comb begin
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        owner_next   = owner_reg;
        i_rdata_next = i_rdata_reg;
        d_rdata_next = d_rdata_reg;

        if (grant) begin
            cnt_next   = '0;
            owner_next = grant_d;
            addr_next  = (grant_d ? d_addr : i_addr) & LINE_MASK;
        end else if (beat_ack) begin
            // Natural wrap 3 -> 0 coincides with the last beat of the burst.
            cnt_next = cnt_reg + 1'b1;
        end

        // Capture the completed line into the owner's return register so it
        // is valid during DONE while the other requester's line is untouched.
        if (last_beat) begin
            if (owner_reg) begin
                d_rdata_next = line_next;
            end else begin
                i_rdata_next = line_next;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            line_reg    <= '0;
            addr_reg    <= '0;
            owner_reg   <= 1'b0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            cnt_reg     <= cnt_next;
            line_reg    <= line_next;
            addr_reg    <= addr_next;
            owner_reg   <= owner_next;
            i_rdata_reg <= i_rdata_next;
            d_rdata_reg <= d_rdata_next;
        end
    end

    // Outgoing write beat follows the counter combinationally; zero otherwise.
    always_comb begin
        mem_wdata = '0;
        if (state_reg == D_WR) begin
            mem_wdata = line_beat[cnt_reg];
        end
    end

    assign mem_addr = addr_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
Arbitrates the instruction cache and data cache onto the single burst memory port of the mp4 top level. It converts 256-bit cacheline requests into 4-beat 64-bit bursts and assembles or serialises lines in a local buffer. It sits between the two caches (upstream) and the burst memory port driven by the testbench (downstream).

Parameters:
LINE_W, 256, cacheline width in bits
BEAT_W, 64, burst beat width in bits
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_read  in  1  icache line read request, held until i_resp
i_addr  in  ADDR_W  icache request address
i_rdata  out  LINE_W  line returned to icache
i_resp  out  1  one-cycle icache completion pulse
d_read  in  1  dcache line read request, held until d_resp
d_write  in  1  dcache line writeback request, held until d_resp
d_addr  in  ADDR_W  dcache request address
d_wdata  in  LINE_W  dcache writeback line
d_rdata  out  LINE_W  line returned to dcache
d_resp  out  1  one-cycle dcache completion pulse
mem_read  out  1  burst read request to memory
mem_write  out  1  burst write request to memory
mem_addr  out  ADDR_W  line-aligned burst address
mem_wdata  out  BEAT_W  current write beat
mem_rdata  in  BEAT_W  current read beat
mem_resp  in  1  per-beat memory acknowledge

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, D_WR, D_RD, I_RD, DONE. Internal state: 2-bit beat counter, LINE_W line buffer, ADDR_W address register, 1-bit owner flag (0 = icache, 1 = dcache).
- Reset: state goes to IDLE; counter, buffer, address and owner are cleared. All outputs are 0, including i_rdata and d_rdata. A reset mid-burst aborts the burst immediately, and mem_read/mem_write are low from the next cycle.
- Arbitration happens in IDLE only, with fixed priority:
  - d_write: go to D_WR and latch d_wdata into the buffer.
  - else d_read: go to D_RD.
  - else i_read: go to I_RD.
  - d_read and d_write together: treated as a write.
- On grant: latch the address with the low 5 bits zeroed, set owner, and clear the counter.
- Memory request timing: mem_read or mem_write asserts on the cycle after grant. It stays high, with a stable mem_addr, until the 4th mem_resp. mem_read and mem_write are never high together.
- Read beats: on each mem_resp in D_RD or I_RD, mem_rdata is written to buffer bits [64*cnt+63 : 64*cnt] and cnt increments.
- Write beats: in D_WR, mem_wdata = buffer bits [64*cnt+63 : 64*cnt], driven combinationally from cnt; cnt increments on each mem_resp.
- End of burst: on mem_resp with cnt == 3, go to DONE. mem_read and mem_write drop on that edge.
- DONE, one cycle:
  - Assert d_resp if owner = 1, else i_resp.
  - d_rdata = buffer when owner = 1; i_rdata = buffer when owner = 0. The non-owner rdata holds its previous value.
  - Requests are not sampled in DONE. Next state is IDLE.
- Latency: the earliest resp is 6 cycles after the request is seen in IDLE: 1 grant cycle, 4 beats with back-to-back mem_resp, 1 DONE cycle. Memory wait states add cycles 1:1.
- mem_resp outside D_RD, D_WR or I_RD is ignored.
- A requester that deasserts mid-burst does not abort the burst. The burst completes and the resp pulse is still issued.
- Back-to-back requests: a pending icache request waits while the dcache is served. It is granted in the IDLE cycle after DONE, provided no dcache request is asserted in that cycle.
- Arithmetic: cnt wraps 3 to 0 only at burst end. Addresses are passed through unchanged except for the aligned low bits.

Test Plan:
- Icache read alone: i_addr = 0x00000064; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_addr = 0x00000060, mem_read high for 4 beats, i_resp for 1 cycle, i_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}, d_resp stays 0.
- Dcache writeback: d_write, d_addr = 0x000010A0, d_wdata = {D3,D2,D1,D0} with Dk = 64'hk...k -> mem_write high, mem_wdata = D0,D1,D2,D3 on successive mem_resp, then d_resp pulse. mem_read is never high.
- Simultaneous i_read and d_read in the same cycle -> dcache burst is serviced first, d_resp at cycle 6; icache granted at cycle 7, i_resp at cycle 12 with zero-wait memory.
- Memory with 3 wait cycles before each beat -> mem_addr stable throughout, beats still land in the correct slices, resp at cycle 18.
- rst asserted after beat 2 of an icache read -> mem_read = 0 next cycle, no i_resp. A fresh i_read after reset completes a normal burst with correct data.
- d_read dropped after beat 1 -> burst still completes 4 beats, d_resp pulses once, and the arbiter returns to IDLE with no retrigger.
